// File: rtl/button_debounce_multi_if.sv
// Button-side bundle for button_debounce_multi: raw inputs in, conditioned levels and pulses out.
// state_dbg packs each channel's 2-bit FSM state (channel i at [2*i+1:2*i]) for observation.
interface button_debounce_multi_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0]   btn_in;
    logic [N_CH-1:0]   btn_level;
    logic [N_CH-1:0]   btn_press;
    logic [N_CH-1:0]   btn_release;
    logic [N_CH-1:0]   btn_long;
    logic              btn_any;
    logic [2*N_CH-1:0] state_dbg;

    // There is no valid/ready handshake on this bundle. btn_in is a free-running
    // asynchronous level. btn_press/btn_release/btn_long are single-cycle pulses that
    // are always accepted. btn_level and btn_any are registered levels.
    modport master (
        output btn_in,
        input  btn_level, btn_press, btn_release, btn_long, btn_any, state_dbg
    );

    modport slave (
        input  btn_in,
        output btn_level, btn_press, btn_release, btn_long, btn_any, state_dbg
    );
endinterface

// File: rtl/button_debounce_multi.sv
// N-channel push-button conditioner: 2-FF synchroniser, stable-time debounce,
// press/release pulses, long-press detection and auto-repeat, all channels independent.
module button_debounce_multi #(
    parameter int N_CH            = 4,
    parameter int DEBOUNCE_CYCLES = 10000,
    parameter int LONG_CYCLES     = 0,
    parameter int REPEAT_CYCLES   = 0,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input logic                    Clk,
    input logic                    Rst_n,
    button_debounce_multi_if.slave bus
);

    localparam int MAX_A = (DEBOUNCE_CYCLES > LONG_CYCLES) ? DEBOUNCE_CYCLES : LONG_CYCLES;
    localparam int MAX_T = (MAX_A > REPEAT_CYCLES) ? MAX_A : REPEAT_CYCLES;
    localparam int CW    = $clog2(MAX_T) + 1;

    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] LONG_LAST = CW'((LONG_CYCLES > 0) ? LONG_CYCLES - 1 : 0);
    localparam logic [CW-1:0] RPT_LAST  = CW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
    localparam bit            LONG_EN   = (LONG_CYCLES > 0);
    localparam bit            RPT_EN    = (REPEAT_CYCLES > 0);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS_W = 2'd1,
        PRESSED = 2'd2,
        REL_W   = 2'd3
    } state_e;

    logic [N_CH-1:0] sync1_q, sync1_d;
    logic [N_CH-1:0] sync2_q, sync2_d;
    state_e          state_q [N_CH];
    state_e          state_d [N_CH];
    logic [CW-1:0]   cnt_q   [N_CH];
    logic [CW-1:0]   cnt_d   [N_CH];
    logic [CW-1:0]   hold_q  [N_CH];
    logic [CW-1:0]   hold_d  [N_CH];
    logic [CW-1:0]   rpt_q   [N_CH];
    logic [CW-1:0]   rpt_d   [N_CH];
    logic [N_CH-1:0] armed_q, armed_d;
    logic [N_CH-1:0] level_q, level_d;
    logic [N_CH-1:0] press_q, press_d;
    logic [N_CH-1:0] release_q, release_d;
    logic [N_CH-1:0] long_q, long_d;
    logic            any_q, any_d;

    // Inversion happens before the first flop so the synchroniser only ever sees "pressed = 1".
    always_comb begin
        sync1_d = bus.btn_in ^ {N_CH{ACTIVE_LOW}};
        sync2_d = sync1_q;
    end

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            state_d[i]   = state_q[i];
            cnt_d[i]     = cnt_q[i];
            hold_d[i]    = hold_q[i];
            rpt_d[i]     = rpt_q[i];
            armed_d[i]   = armed_q[i];
            level_d[i]   = level_q[i];
            press_d[i]   = 1'b0;
            release_d[i] = 1'b0;
            long_d[i]    = 1'b0;

            case (state_q[i])
                IDLE: begin
                    if (sync2_q[i]) begin
                        state_d[i] = PRESS_W;
                        cnt_d[i]   = CW'(1);
                    end
                end
                PRESS_W: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == DEB_LAST) begin
                        state_d[i] = PRESSED;
                        cnt_d[i]   = '0;
                        level_d[i] = 1'b1;
                        press_d[i] = 1'b1;
                        hold_d[i]  = '0;
                        rpt_d[i]   = '0;
                        armed_d[i] = 1'b0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                end
                PRESSED: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = REL_W;
                        cnt_d[i]   = CW'(1);
                        rpt_d[i]   = '0;
                    end else begin
                        hold_d[i] = (hold_q[i] == '1) ? hold_q[i] : hold_q[i] + CW'(1);
                        // Repeat timer is only checked once armed, so it can never collide with btn_long.
                        if (LONG_EN && hold_q[i] == LONG_LAST) begin
                            long_d[i]  = 1'b1;
                            armed_d[i] = RPT_EN;
                            rpt_d[i]   = '0;
                        end else if (armed_q[i]) begin
                            if (rpt_q[i] == RPT_LAST) begin
                                press_d[i] = 1'b1;
                                rpt_d[i]   = '0;
                            end else begin
                                rpt_d[i] = rpt_q[i] + CW'(1);
                            end
                        end
                    end
                end
                REL_W: begin
                    if (sync2_q[i]) begin
                        state_d[i] = PRESSED;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == DEB_LAST) begin
                        state_d[i]   = IDLE;
                        cnt_d[i]     = '0;
                        level_d[i]   = 1'b0;
                        release_d[i] = 1'b1;
                        armed_d[i]   = 1'b0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
        any_d = |level_d;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            armed_q   <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            long_q    <= '0;
            any_q     <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
                hold_q[i]  <= '0;
                rpt_q[i]   <= '0;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            armed_q   <= armed_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            any_q     <= any_d;
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                hold_q[i]  <= hold_d[i];
                rpt_q[i]   <= rpt_d[i];
            end
        end
    end

    assign bus.btn_level   = level_q;
    assign bus.btn_press   = press_q;
    assign bus.btn_release = release_q;
    assign bus.btn_long    = long_q;
    assign bus.btn_any     = any_q;

    for (genvar g = 0; g < N_CH; g++) begin : g_dbg
        assign bus.state_dbg[2*g +: 2] = state_q[g];
    end

endmodule

// File: tb/tb_button_debounce_multi.sv
// Directed bench for button_debounce_multi: an active-high instance exercises every scenario,
// and an active-low instance repeats the clean press with inverted inputs.
module tb_button_debounce_multi;

    localparam int N_CH = 2;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;

    // Observation word layout: {level[1:0], press[1:0], release[1:0], long[1:0], any}
    logic [8:0] obs;
    logic [8:0] exp_v;
    logic [7:0] exp_q[$];

    button_debounce_multi_if #(.N_CH(N_CH)) bi ();
    button_debounce_multi_if #(.N_CH(N_CH)) bl ();

    button_debounce_multi #(
        .N_CH(N_CH), .DEBOUNCE_CYCLES(8), .LONG_CYCLES(32), .REPEAT_CYCLES(16), .ACTIVE_LOW(1'b0)
    ) u_dut (
        .Clk(clk), .Rst_n(rst_n), .bus(bi)
    );

    button_debounce_multi #(
        .N_CH(N_CH), .DEBOUNCE_CYCLES(8), .LONG_CYCLES(32), .REPEAT_CYCLES(16), .ACTIVE_LOW(1'b1)
    ) u_dut_al (
        .Clk(clk), .Rst_n(rst_n), .bus(bl)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_gap();
        int n;
        n = $urandom_range(2, 6);
        for (int k = 0; k < n; k++) begin
            tick();
            obs = {bi.btn_level, bi.btn_press, bi.btn_release, bi.btn_long, bi.btn_any};
            n_total++;
            if (obs !== 9'b0) begin
                n_bad++;
                $display("FAIL idle_quiet got=%b want=%b", obs, 9'b0);
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n     = 1'b0;
        bi.btn_in = 2'b00;
        bl.btn_in = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        obs = {bi.btn_level, bi.btn_press, bi.btn_release, bi.btn_long, bi.btn_any};
        n_total++;
        if (obs !== 9'b0) begin
            n_bad++;
            $display("FAIL reset_outputs got=%b want=%b", obs, 9'b0);
        end
        n_total++;
        if (bi.state_dbg !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_state got=%b want=%b", bi.state_dbg, 4'b0000);
        end
        obs = {bl.btn_level, bl.btn_press, bl.btn_release, bl.btn_long, bl.btn_any};
        n_total++;
        if (obs !== 9'b0) begin
            n_bad++;
            $display("FAIL reset_outputs_al got=%b want=%b", obs, 9'b0);
        end
        rst_n = 1'b1;
        idle_gap();
        // Inactive active-low inputs (high) must not look like a press once out of reset.
        obs = {bl.btn_level, bl.btn_press, bl.btn_release, bl.btn_long, bl.btn_any};
        n_total++;
        if (obs !== 9'b0) begin
            n_bad++;
            $display("FAIL al_idle_after_reset got=%b want=%b", obs, 9'b0);
        end
    endtask

    task automatic test_clean_press();
        idle_gap();
        bi.btn_in = 2'b01;
        for (int k = 1; k <= 20; k++) begin
            tick();
            obs   = {bi.btn_level, bi.btn_press, bi.btn_release, bi.btn_long, bi.btn_any};
            exp_v = {(k >= 10) ? 2'b01 : 2'b00, (k == 10) ? 2'b01 : 2'b00, 2'b00, 2'b00, k >= 10};
            n_total++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL clean_press k=%0d got=%b want=%b", k, obs, exp_v);
            end
        end
        bi.btn_in = 2'b00;
        for (int k = 1; k <= 12; k++) begin
            tick();
            obs   = {bi.btn_level, bi.btn_press, bi.btn_release, bi.btn_long, bi.btn_any};
            exp_v = {(k < 10) ? 2'b01 : 2'b00, 2'b00, (k == 10) ? 2'b01 : 2'b00, 2'b00, k < 10};
            n_total++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL clean_release k=%0d got=%b want=%b", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_bounce();
        idle_gap();
        bi.btn_in = 2'b01;
        for (int k = 1; k <= 6; k++) begin
            if (k == 6) bi.btn_in = 2'b00;
            tick();
            n_total++;
            if (bi.btn_press !== 2'b00) begin
                n_bad++;
                $display("FAIL bounce_early_press k=%0d got=%b want=%b", k, bi.btn_press, 2'b00);
            end
        end
        bi.btn_in = 2'b01;
        for (int k = 1; k <= 20; k++) begin
            tick();
            obs   = {bi.btn_level, bi.btn_press, bi.btn_release, bi.btn_long, bi.btn_any};
            exp_v = {(k >= 10) ? 2'b01 : 2'b00, (k == 10) ? 2'b01 : 2'b00, 2'b00, 2'b00, k >= 10};
            n_total++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL bounce_press k=%0d got=%b want=%b", k, obs, exp_v);
            end
        end
        bi.btn_in = 2'b00;
        for (int k = 1; k <= 12; k++) begin
            tick();
            n_total++;
            if (bi.btn_release !== ((k == 10) ? 2'b01 : 2'b00)) begin
                n_bad++;
                $display("FAIL bounce_release k=%0d got=%b want=%b", k, bi.btn_release,
                         (k == 10) ? 2'b01 : 2'b00);
            end
        end
    endtask

    task automatic test_long_repeat();
        idle_gap();
        exp_q = {8'd10, 8'd58, 8'd74};
        bi.btn_in = 2'b10;
        for (int k = 1; k <= 80; k++) begin
            tick();
            obs   = {bi.btn_level, bi.btn_press, bi.btn_release, bi.btn_long, bi.btn_any};
            exp_v = {(k >= 10) ? 2'b10 : 2'b00,
                     (exp_q.size() > 0 && exp_q[0] == 8'(k)) ? 2'b10 : 2'b00,
                     2'b00,
                     (k == 42) ? 2'b10 : 2'b00,
                     k >= 10};
            if (exp_q.size() > 0 && exp_q[0] == 8'(k)) void'(exp_q.pop_front());
            n_total++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL long_repeat k=%0d got=%b want=%b", k, obs, exp_v);
            end
        end
        bi.btn_in = 2'b00;
        for (int k = 1; k <= 12; k++) begin
            tick();
            obs   = {bi.btn_level, bi.btn_press, bi.btn_release, bi.btn_long, bi.btn_any};
            exp_v = {(k < 10) ? 2'b10 : 2'b00, 2'b00, (k == 10) ? 2'b10 : 2'b00, 2'b00, k < 10};
            n_total++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL long_release k=%0d got=%b want=%b", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_release_glitch();
        idle_gap();
        bi.btn_in = 2'b01;
        for (int k = 1; k <= 12; k++) begin
            tick();
            n_total++;
            if (bi.btn_press !== ((k == 10) ? 2'b01 : 2'b00)) begin
                n_bad++;
                $display("FAIL glitch_press k=%0d got=%b want=%b", k, bi.btn_press,
                         (k == 10) ? 2'b01 : 2'b00);
            end
        end
        bi.btn_in = 2'b00;
        for (int k = 1; k <= 23; k++) begin
            if (k == 4) bi.btn_in = 2'b01;
            tick();
            obs   = {bi.btn_level, bi.btn_press, bi.btn_release, bi.btn_long, bi.btn_any};
            exp_v = {2'b01, 2'b00, 2'b00, 2'b00, 1'b1};
            n_total++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL glitch_hold k=%0d got=%b want=%b", k, obs, exp_v);
            end
        end
        bi.btn_in = 2'b00;
        for (int k = 1; k <= 12; k++) begin
            tick();
            obs   = {bi.btn_level, bi.btn_press, bi.btn_release, bi.btn_long, bi.btn_any};
            exp_v = {(k < 10) ? 2'b01 : 2'b00, 2'b00, (k == 10) ? 2'b01 : 2'b00, 2'b00, k < 10};
            n_total++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL glitch_release k=%0d got=%b want=%b", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_simultaneous();
        idle_gap();
        bi.btn_in = 2'b11;
        for (int k = 1; k <= 12; k++) begin
            tick();
            obs   = {bi.btn_level, bi.btn_press, bi.btn_release, bi.btn_long, bi.btn_any};
            exp_v = {(k >= 10) ? 2'b11 : 2'b00, (k == 10) ? 2'b11 : 2'b00, 2'b00, 2'b00, k >= 10};
            n_total++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL both_press k=%0d got=%b want=%b", k, obs, exp_v);
            end
        end
        bi.btn_in = 2'b00;
        for (int k = 1; k <= 12; k++) begin
            tick();
            obs   = {bi.btn_level, bi.btn_press, bi.btn_release, bi.btn_long, bi.btn_any};
            exp_v = {(k < 10) ? 2'b11 : 2'b00, 2'b00, (k == 10) ? 2'b11 : 2'b00, 2'b00, k < 10};
            n_total++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL both_release k=%0d got=%b want=%b", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_press();
        idle_gap();
        bi.btn_in = 2'b01;
        for (int k = 1; k <= 12; k++) begin
            tick();
            n_total++;
            if (bi.btn_level !== ((k >= 10) ? 2'b01 : 2'b00)) begin
                n_bad++;
                $display("FAIL rst_pre_level k=%0d got=%b want=%b", k, bi.btn_level,
                         (k >= 10) ? 2'b01 : 2'b00);
            end
        end
        #1;
        rst_n = 1'b0;
        #1;
        obs = {bi.btn_level, bi.btn_press, bi.btn_release, bi.btn_long, bi.btn_any};
        n_total++;
        if (obs !== 9'b0) begin
            n_bad++;
            $display("FAIL rst_async_drop got=%b want=%b", obs, 9'b0);
        end
        n_total++;
        if (bi.state_dbg !== 4'b0000) begin
            n_bad++;
            $display("FAIL rst_async_state got=%b want=%b", bi.state_dbg, 4'b0000);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            obs   = {bi.btn_level, bi.btn_press, bi.btn_release, bi.btn_long, bi.btn_any};
            exp_v = {(k >= 10) ? 2'b01 : 2'b00, (k == 10) ? 2'b01 : 2'b00, 2'b00, 2'b00, k >= 10};
            n_total++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL rst_fresh_press k=%0d got=%b want=%b", k, obs, exp_v);
            end
        end
        bi.btn_in = 2'b00;
        for (int k = 1; k <= 12; k++) begin
            tick();
            n_total++;
            if (bi.btn_release !== ((k == 10) ? 2'b01 : 2'b00)) begin
                n_bad++;
                $display("FAIL rst_release k=%0d got=%b want=%b", k, bi.btn_release,
                         (k == 10) ? 2'b01 : 2'b00);
            end
        end
    endtask

    task automatic test_active_low();
        idle_gap();
        bl.btn_in = 2'b10;
        for (int k = 1; k <= 20; k++) begin
            tick();
            obs   = {bl.btn_level, bl.btn_press, bl.btn_release, bl.btn_long, bl.btn_any};
            exp_v = {(k >= 10) ? 2'b01 : 2'b00, (k == 10) ? 2'b01 : 2'b00, 2'b00, 2'b00, k >= 10};
            n_total++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL al_press k=%0d got=%b want=%b", k, obs, exp_v);
            end
        end
        bl.btn_in = 2'b11;
        for (int k = 1; k <= 12; k++) begin
            tick();
            obs   = {bl.btn_level, bl.btn_press, bl.btn_release, bl.btn_long, bl.btn_any};
            exp_v = {(k < 10) ? 2'b01 : 2'b00, 2'b00, (k == 10) ? 2'b01 : 2'b00, 2'b00, k < 10};
            n_total++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL al_release k=%0d got=%b want=%b", k, obs, exp_v);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_total   = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        bi.btn_in = 2'b00;
        bl.btn_in = 2'b11;
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_repeat();
        test_release_glitch();
        test_simultaneous();
        test_reset_mid_press();
        test_active_low();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
